// File: rtl/crc8_frame_ctrl.sv
// ----------------------------------------------------------------------------
// crc8_frame_ctrl
//
// Frame-level sequencer wrapped around an external crc8_core (polynomial 0x07,
// initial value 0x00). Bytes flow from the s_* stream to the m_* stream through
// a single output register. Every accepted byte is also fed to the core, which
// is held in reset for the one IDLE cycle that precedes each frame.
//
// APPEND mode (mode_i = 0): the frame is forwarded and the CRC byte is added
// after it, carrying m_last_o. frame_len_o reports the emitted length
// including the CRC byte.
// CHECK mode (mode_i = 1): the frame, including its trailing CRC byte, is
// forwarded unmodified. One cycle after the last byte is accepted, a
// status_valid_o pulse reports crc_ok_o and frame_len_o.
//
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   mode_i                0 = APPEND, 1 = CHECK; sampled in IDLE only
//   s_data_i/s_valid_i/s_last_i/s_ready_o   input byte stream
//   m_data_o/m_valid_o/m_last_o/m_ready_i   output byte stream
//   crc_rst_o/crc_data_o/crc_valid_o        drive the external core
//   crc_i                 core result, valid 1 cycle after its last update
//   status_valid_o        1-cycle pulse: CHECK result available
//   crc_ok_o              CHECK result, held until the next pulse
//   frame_len_o           length of the completed frame (saturating)
// ----------------------------------------------------------------------------
module crc8_frame_ctrl #(
    parameter int LEN_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             mode_i,
    input  logic [7:0]       s_data_i,
    input  logic             s_valid_i,
    input  logic             s_last_i,
    output logic             s_ready_o,
    output logic [7:0]       m_data_o,
    output logic             m_valid_o,
    output logic             m_last_o,
    input  logic             m_ready_i,
    output logic             crc_rst_o,
    output logic [7:0]       crc_data_o,
    output logic             crc_valid_o,
    input  logic [7:0]       crc_i,
    output logic             status_valid_o,
    output logic             crc_ok_o,
    output logic [LEN_W-1:0] frame_len_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PASS   = 2'd1,
        SETTLE = 2'd2,
        APPEND = 2'd3
    } state_t;

    localparam logic [LEN_W-1:0] LEN_MAX = '1;

    state_t           state;
    state_t           next_state;
    logic             mode_q;
    logic [LEN_W-1:0] count;
    logic [7:0]       crc_q;

    logic             out_free;
    logic             accept;

    // Controls produced by the next-state logic for the datapath registers
    logic             load_out;
    logic [7:0]       load_data;
    logic             load_last;
    logic             clear_count;
    logic             capture_crc;
    logic             report;
    logic             append_done;

    // Counter increment that sticks at the top of its range
    function automatic logic [LEN_W-1:0] sat_inc(input logic [LEN_W-1:0] v);
        return (v == LEN_MAX) ? v : v + 1'b1;
    endfunction

    // The output register can take a new byte when it is empty or its
    // current byte is leaving on this edge.
    assign out_free    = !m_valid_o || m_ready_i;
    assign s_ready_o   = (state == PASS) && out_free;
    assign accept      = s_valid_i && s_ready_o;

    // The core sees exactly the accepted bytes and is cleared before each frame
    assign crc_rst_o   = (state == IDLE);
    assign crc_valid_o = accept;
    assign crc_data_o  = s_data_i;

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and datapath control. SETTLE exists because the core needs
    // one cycle after the final byte before crc_i reflects the whole frame.
    always_comb begin
        next_state  = state;
        load_out    = 1'b0;
        load_data   = s_data_i;
        load_last   = 1'b0;
        clear_count = 1'b0;
        capture_crc = 1'b0;
        report      = 1'b0;
        append_done = 1'b0;
        case (state)
            IDLE: begin
                clear_count = 1'b1;
                next_state  = PASS;
            end
            PASS: begin
                if (accept) begin
                    load_out  = 1'b1;
                    load_last = s_last_i && mode_q;
                    if (s_last_i) begin
                        next_state = SETTLE;
                    end
                end
            end
            SETTLE: begin
                if (mode_q) begin
                    report     = 1'b1;
                    next_state = IDLE;
                end else begin
                    capture_crc = 1'b1;
                    next_state  = APPEND;
                end
            end
            APPEND: begin
                if (out_free) begin
                    load_out    = 1'b1;
                    load_data   = crc_q;
                    load_last   = 1'b1;
                    append_done = 1'b1;
                    next_state  = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Output stage: holds its byte steady while downstream stalls and
    // empties once the byte is taken with nothing new behind it.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            m_data_o  <= 8'h00;
            m_valid_o <= 1'b0;
            m_last_o  <= 1'b0;
        end else if (load_out) begin
            m_data_o  <= load_data;
            m_valid_o <= 1'b1;
            m_last_o  <= load_last;
        end else if (m_valid_o && m_ready_i) begin
            m_valid_o <= 1'b0;
        end
    end

    // Frame bookkeeping: mode is frozen for the whole frame at IDLE, the
    // byte counter runs over accepted bytes, and the CRC is parked in
    // crc_q until the output register is free to emit it.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mode_q <= 1'b0;
            count  <= '0;
            crc_q  <= 8'h00;
        end else begin
            if (clear_count) begin
                mode_q <= mode_i;
                count  <= '0;
            end else if (accept) begin
                count <= sat_inc(count);
            end
            if (capture_crc) begin
                crc_q <= crc_i;
            end
        end
    end

    // Status reporting. A CHECK frame is good when the running CRC over
    // all of its bytes, trailing CRC included, comes out to zero.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            status_valid_o <= 1'b0;
            crc_ok_o       <= 1'b0;
            frame_len_o    <= '0;
        end else begin
            status_valid_o <= report;
            if (report) begin
                crc_ok_o    <= (crc_i == 8'h00);
                frame_len_o <= count;
            end else if (append_done) begin
                frame_len_o <= sat_inc(count);
            end
        end
    end

endmodule

// File: tb/tb_crc8_frame_ctrl.sv
// ----------------------------------------------------------------------------
// tb_crc8_frame_ctrl
//
// Scoreboard bench for crc8_frame_ctrl. Frames are issued by applyStimulus,
// which pushes the expected output bytes and CHECK results into queues; two
// independent monitors pop and compare whenever the DUT transfers a byte or
// pulses status. A small behavioural crc8_core stands in for the external
// core. Expected CRCs come from a frame-level polynomial long division.
// The DUT is built with LEN_W = 5 so the saturating length is reachable.
// ----------------------------------------------------------------------------
module tb_crc8_frame_ctrl;

    localparam int LW = 5;
    localparam logic [LW-1:0] LEN_MAX = '1;

    logic          clk = 1'b0;
    logic          rst_i;
    logic          mode_i;
    logic [7:0]    s_data_i;
    logic          s_valid_i;
    logic          s_last_i;
    logic          s_ready_o;
    logic [7:0]    m_data_o;
    logic          m_valid_o;
    logic          m_last_o;
    logic          m_ready_i;
    logic          crc_rst_o;
    logic [7:0]    crc_data_o;
    logic          crc_valid_o;
    logic [7:0]    crc_i;
    logic          status_valid_o;
    logic          crc_ok_o;
    logic [LW-1:0] frame_len_o;

    crc8_frame_ctrl #(.LEN_W(LW)) dut (
        .clk_i          (clk),
        .rst_i          (rst_i),
        .mode_i         (mode_i),
        .s_data_i       (s_data_i),
        .s_valid_i      (s_valid_i),
        .s_last_i       (s_last_i),
        .s_ready_o      (s_ready_o),
        .m_data_o       (m_data_o),
        .m_valid_o      (m_valid_o),
        .m_last_o       (m_last_o),
        .m_ready_i      (m_ready_i),
        .crc_rst_o      (crc_rst_o),
        .crc_data_o     (crc_data_o),
        .crc_valid_o    (crc_valid_o),
        .crc_i          (crc_i),
        .status_valid_o (status_valid_o),
        .crc_ok_o       (crc_ok_o),
        .frame_len_o    (frame_len_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0]  data;
        logic        last;
        logic        chk_len;
        logic [31:0] len;
    } out_exp_t;

    typedef struct packed {
        logic        ok;
        logic [31:0] len;
    } stat_exp_t;

    out_exp_t   exp_q[$];
    stat_exp_t  stat_q[$];
    logic [7:0] frame[$];

    int checks_total  = 0;
    int checks_passed = 0;
    int cyc           = 0;
    int last_acc_cyc  = 0;
    int first_acc_cyc = 0;
    int rst_run       = 0;

    bit ready_random    = 1'b0;
    bit ready_force_low = 1'b0;
    bit gap_en          = 1'b0;
    bit flip_en         = 1'b0;
    bit rand_modes[0:40];

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural stand-in for the external crc8_core (one update per byte)
    logic [7:0] core_crc;
    assign crc_i = core_crc;

    function automatic logic [7:0] core_step(input logic [7:0] c, input logic [7:0] d);
        logic [7:0] x;
        x = c ^ d;
        for (int k = 0; k < 8; k++) begin
            x = x[7] ? ((x << 1) ^ 8'h07) : (x << 1);
        end
        return x;
    endfunction

    always @(posedge clk) begin
        if (crc_rst_o) core_crc <= 8'h00;
        else if (crc_valid_o) core_crc <= core_step(core_crc, crc_data_o);
    end

    // Reference: remainder of (frame * x^8) divided by x^8+x^2+x+1
    function automatic logic [7:0] crc_of_frame();
        logic [8:0] rem;
        logic       in_bit;
        rem = 9'h000;
        for (int i = 0; i <= frame.size(); i++) begin
            for (int b = 7; b >= 0; b--) begin
                in_bit = (i < frame.size()) ? frame[i][b] : 1'b0;
                rem = {rem[7:0], in_bit};
                if (rem[8]) rem = rem ^ 9'h107;
            end
        end
        return rem[7:0];
    endfunction

    function automatic int sat(input int n);
        return (n > int'(LEN_MAX)) ? int'(LEN_MAX) : n;
    endfunction

    task automatic checkOutput(input string name, input int act, input int req);
        checks_total++;
        if (act == req) checks_passed++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    endtask

    // Downstream ready generator
    initial begin
        m_ready_i = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (ready_force_low) m_ready_i = 1'b0;
            else if (ready_random) m_ready_i = ($urandom_range(0, 3) != 0);
            else m_ready_i = 1'b1;
        end
    end

    // Output byte monitor
    always @(negedge clk) begin
        if (m_valid_o && m_ready_i) begin
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_byte", int'(m_data_o), -1);
            end else begin
                out_exp_t e;
                e = exp_q.pop_front();
                checkOutput("out_data", int'(m_data_o), int'(e.data));
                checkOutput("out_last", int'(m_last_o), int'(e.last));
                if (e.chk_len) checkOutput("append_len", int'(frame_len_o), int'(e.len));
            end
        end
    end

    // Status monitor
    always @(negedge clk) begin
        if (status_valid_o) begin
            if (stat_q.size() == 0) begin
                checkOutput("unexpected_status", 1, 0);
            end else begin
                stat_exp_t s;
                s = stat_q.pop_front();
                checkOutput("crc_ok", int'(crc_ok_o), int'(s.ok));
                checkOutput("check_len", int'(frame_len_o), int'(s.len));
                checkOutput("status_latency", cyc - last_acc_cyc, 1);
            end
        end
    end

    // Core reset must be a single cycle ahead of each frame
    always @(negedge clk) begin
        if (rst_i) begin
            rst_run = 0;
        end else if (crc_rst_o) begin
            rst_run++;
        end else if (rst_run > 0) begin
            checkOutput("crc_rst_width", rst_run, 1);
            rst_run = 0;
        end
    end

    // Offer one byte and wait (bounded) for it to be accepted
    task automatic driveByte(input logic [7:0] d, input logic last);
        int  waited;
        bit  done;
        waited = 0;
        done   = 1'b0;
        if (gap_en) begin
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
        end
        s_valid_i = 1'b1;
        s_data_i  = d;
        s_last_i  = last;
        while (!done) begin
            @(negedge clk);
            if (s_ready_o) begin
                done = 1'b1;
            end else begin
                waited++;
                if (waited > 300) begin
                    checkOutput("accept_timeout", waited, 0);
                    done = 1'b1;
                end
            end
            @(posedge clk);
            #1;
        end
        last_acc_cyc = cyc;
        s_valid_i = 1'b0;
        s_last_i  = 1'b0;
    endtask

    // Issue the frame held in 'frame'; next_mode is presented right after
    // the last byte so it is what the following IDLE latches.
    task automatic applyStimulus(input logic mode, input logic next_mode);
        int         n;
        logic [7:0] crc;
        n   = frame.size();
        crc = crc_of_frame();
        for (int i = 0; i < n; i++) begin
            exp_q.push_back('{frame[i], (mode && (i == n - 1)), 1'b0, 32'd0});
        end
        if (!mode) exp_q.push_back('{crc, 1'b1, 1'b1, 32'(sat(n + 1))});
        else stat_q.push_back('{(crc == 8'h00), 32'(sat(n))});
        for (int i = 0; i < n; i++) begin
            driveByte(frame[i], (i == n - 1));
            if (i == 0) first_acc_cyc = last_acc_cyc;
            if (flip_en && i == 0 && n >= 2) mode_i = ~mode_i;
        end
        mode_i = next_mode;
    endtask

    task automatic drain();
        int w;
        w = 0;
        while ((exp_q.size() != 0 || stat_q.size() != 0) && w < 500) begin
            @(posedge clk);
            #1;
            w++;
        end
        checkOutput("drain_bytes", exp_q.size(), 0);
        checkOutput("drain_status", stat_q.size(), 0);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        string s;
        int    n;
        int    w;
        rst_i     = 1'b1;
        mode_i    = 1'b0;
        s_valid_i = 1'b0;
        s_data_i  = 8'h00;
        s_last_i  = 1'b0;
        for (int i = 0; i <= 40; i++) rand_modes[i] = $urandom_range(0, 1) != 0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_m_valid", int'(m_valid_o), 0);
        checkOutput("rst_m_last", int'(m_last_o), 0);
        checkOutput("rst_m_data", int'(m_data_o), 0);
        checkOutput("rst_status", int'(status_valid_o), 0);
        checkOutput("rst_crc_ok", int'(crc_ok_o), 0);
        checkOutput("rst_frame_len", int'(frame_len_o), 0);
        checkOutput("rst_crc_rst", int'(crc_rst_o), 1);
        checkOutput("rst_s_ready", int'(s_ready_o), 0);
        @(posedge clk);
        #1;
        rst_i = 1'b0;

        $display("[TB] APPEND 01 02");
        frame = '{8'h01, 8'h02};
        applyStimulus(1'b0, 1'b0);
        @(negedge clk);
        checkOutput("byte_latency", int'({m_valid_o, m_data_o}), 'h102);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        checkOutput("crc_latency", int'({m_valid_o, m_last_o, m_data_o}), 'h31B);
        @(posedge clk);
        #1;

        $display("[TB] APPEND 123456789");
        s = "123456789";
        frame.delete();
        for (int i = 0; i < s.len(); i++) frame.push_back(s[i]);
        applyStimulus(1'b0, 1'b1);
        checkOutput("back_to_back", last_acc_cyc - first_acc_cyc, 8);

        $display("[TB] CHECK good and bad frames");
        frame = '{8'h01, 8'h02, 8'h1B};
        applyStimulus(1'b1, 1'b1);
        frame = '{8'h01, 8'h02, 8'h1C};
        applyStimulus(1'b1, 1'b0);

        $display("[TB] APPEND with stalled CRC byte");
        frame = '{8'h01, 8'h02};
        applyStimulus(1'b0, 1'b1);
        @(posedge clk);
        ready_force_low = 1'b1;
        w = 0;
        @(negedge clk);
        while (!m_valid_o && w < 10) begin
            @(negedge clk);
            w++;
        end
        for (int k = 0; k < 5; k++) begin
            checkOutput("hold_valid", int'(m_valid_o), 1);
            checkOutput("hold_data", int'(m_data_o), 'h1B);
            checkOutput("hold_last", int'(m_last_o), 1);
            checkOutput("hold_s_ready", int'(s_ready_o), 0);
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        ready_force_low = 1'b0;
        drain();

        $display("[TB] reset mid-frame");
        exp_q.push_back('{8'hAA, 1'b0, 1'b0, 32'd0});
        exp_q.push_back('{8'hBB, 1'b0, 1'b0, 32'd0});
        exp_q.push_back('{8'hCC, 1'b0, 1'b0, 32'd0});
        driveByte(8'hAA, 1'b0);
        driveByte(8'hBB, 1'b0);
        driveByte(8'hCC, 1'b0);
        @(posedge clk);
        #1;
        rst_i  = 1'b1;
        mode_i = 1'b0;
        @(posedge clk);
        #1;
        rst_i = 1'b0;
        @(negedge clk);
        checkOutput("midrst_m_valid", int'(m_valid_o), 0);
        checkOutput("midrst_status", int'(status_valid_o), 0);
        checkOutput("midrst_idle", int'(crc_rst_o), 1);
        @(posedge clk);
        #1;
        frame = '{8'h01, 8'h02};
        applyStimulus(1'b0, 1'b1);

        $display("[TB] CHECK single-byte frames");
        frame = '{8'h00};
        applyStimulus(1'b1, 1'b1);
        frame = '{8'h05};
        applyStimulus(1'b1, 1'b0);

        $display("[TB] saturating length");
        frame.delete();
        for (int i = 0; i < 35; i++) frame.push_back(8'($urandom));
        applyStimulus(1'b0, 1'b1);
        frame.delete();
        for (int i = 0; i < 35; i++) frame.push_back(8'($urandom));
        applyStimulus(1'b1, rand_modes[0]);
        drain();

        $display("[TB] random frames");
        ready_random = 1'b1;
        gap_en       = 1'b1;
        flip_en      = 1'b1;
        for (int f = 0; f < 40; f++) begin
            n = $urandom_range(1, 10);
            frame.delete();
            if (rand_modes[f] && ($urandom_range(0, 1) != 0)) begin
                for (int i = 0; i < n - 1; i++) frame.push_back(8'($urandom));
                frame.push_back(crc_of_frame());
            end else begin
                for (int i = 0; i < n; i++) frame.push_back(8'($urandom));
            end
            applyStimulus(rand_modes[f], rand_modes[f + 1]);
        end
        ready_random = 1'b0;
        gap_en       = 1'b0;
        flip_en      = 1'b0;
        drain();

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule

// File: doc/crc8_frame_ctrl.md
Name: crc8_frame_ctrl

Overview:
Frame-level sequencer for an external crc8_core instance with default POLYNOMIAL 8'h07 and INITIAL 8'h00. It passes a byte stream with valid/ready/last framing from input to output and resets the core at every frame start. It feeds each accepted byte to the core. In APPEND mode it adds the CRC byte after the frame; in CHECK mode it checks the trailing CRC byte of the frame and reports pass/fail with the frame length. It sits between the packet source and the serializer on both the trigger TX and RX paths.

Parameters:
LEN_W, 16, width of the frame byte counter and frame_len_o. The counter saturates at 2^LEN_W-1.

Ports:
clk_i  input  1  clock
rst_i  input  1  synchronous, active-high reset
mode_i  input  1  0 = APPEND, 1 = CHECK; sampled only in IDLE
s_data_i  input  8  input stream byte
s_valid_i  input  1  input byte valid
s_last_i  input  1  input byte is the last byte of the frame
s_ready_o  output  1  controller can accept an input byte
m_data_o  output  8  output stream byte
m_valid_o  output  1  output byte valid
m_last_o  output  1  output byte is the last byte of the frame
m_ready_i  input  1  downstream accepts the output byte
crc_rst_o  output  1  reset to the core
crc_data_o  output  8  data to the core
crc_valid_o  output  1  data_valid to the core
crc_i  input  8  crc_o from the core; valid 1 cycle after the last crc_valid_o
status_valid_o  output  1  1-cycle pulse: CHECK result available
crc_ok_o  output  1  CHECK result, held until the next status pulse
frame_len_o  output  LEN_W  bytes in the completed frame, held until the next status pulse or APPEND completion

Behaviour:
- Reset (synchronous, rst_i high on a clock edge):
  - state = IDLE.
  - m_valid_o=0, m_last_o=0, m_data_o=0.
  - status_valid_o=0, crc_ok_o=0, frame_len_o=0.
  - Byte counter = 0.
  - Reset mid-frame drops the frame. No status pulse is produced and no CRC byte is appended.
- Output stage: a single register. out_free = !m_valid_o || m_ready_i. When a byte transfers (m_valid_o && m_ready_i) and no new byte loads, m_valid_o clears.
- Combinational outputs:
  - crc_rst_o = (state==IDLE).
  - s_ready_o = (state==PASS) && out_free.
  - crc_valid_o = s_valid_i && s_ready_o.
  - crc_data_o = s_data_i.
- States:
  - IDLE: 1 cycle. Latch mode_i into mode_q, clear the counter, go to PASS. The core is held in reset for this cycle.
  - PASS: on each accept, load m_data_o=s_data_i, set m_valid_o=1, set m_last_o = s_last_i && mode_q, and increment the counter (saturating).
    - Accept with s_last_i=1 goes to SETTLE.
    - Accepts may be back-to-back, one byte per clock.
  - SETTLE: 1 cycle, no accept. crc_i now covers every frame byte.
    - APPEND: capture crc_i into crc_q, go to APPEND.
    - CHECK: crc_ok_o=(crc_i==8'h00), frame_len_o=counter, status_valid_o=1 for this one cycle, go to IDLE.
  - APPEND: wait for out_free. Then load m_data_o=crc_q, m_valid_o=1, m_last_o=1, frame_len_o=counter+1 (saturating), go to IDLE.
- Latency:
  - Input byte to m_valid_o: 1 cycle.
  - Last input accept to CRC byte on m_valid_o: 2 cycles when the output is free.
  - Last input accept to status_valid_o: 1 cycle.
  - Frame-to-frame overhead: SETTLE + IDLE (CHECK), or SETTLE + APPEND + IDLE (APPEND). s_ready_o is low in these states.
- Backpressure: with m_ready_i low, s_ready_o is low in PASS and APPEND holds. m_data_o, m_valid_o and m_last_o stay stable while m_valid_o && !m_ready_i.
- CHECK mode forwards every byte, including the received CRC byte, unmodified. m_last_o marks the received CRC byte.
- A 1-byte CHECK frame is valid; its CRC is its only byte, so ok iff the byte is 0x00.
- A mode_i change outside IDLE has no effect until the next frame.
- The core's 1-cycle update latency is the only timing assumed; crc_i is not read in PASS.

Test Plan:
1. APPEND, bytes 01,02 (last on 02), m_ready_i=1 -> output 01, 02, then 1B with m_last_o only on 1B; frame_len_o=3; crc_rst_o high exactly 1 cycle before each frame.
2. APPEND, ASCII "123456789" back-to-back -> 9 bytes forwarded, then F4 with m_last_o; s_ready_o high for 9 consecutive cycles.
3. CHECK, bytes 01,02,1B -> status_valid_o 1-cycle pulse 1 cycle after the accept of 1B; crc_ok_o=1, frame_len_o=3. Then a second frame 01,02,1C -> crc_ok_o=0.
4. APPEND, 01,02 with m_ready_i low for 5 cycles while 1B is pending -> m_data_o=1B and m_valid_o=1 stable throughout; single transfer of 1B when released; no input accepted until IDLE->PASS.
5. rst_i asserted for 1 cycle mid-frame after 3 bytes -> next cycle m_valid_o=0 and state=IDLE, no status pulse. A following APPEND frame 01,02 still yields 1B.
6. CHECK, single-byte frames 00 then 05 -> crc_ok_o=1 then 0, frame_len_o=1 both times.
